// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: RV32I/M decode with ID/EX control register and M-op latency sequencer
module pipelined_control_unit #(
  parameter bit M_EXT       = 1'b1,
  parameter int MUL_LATENCY = 2,
  parameter int DIV_LATENCY = 33,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic        ValidD,
  input  logic        FlushE,
  output logic [2:0]  ImmSrcD,
  output logic        RegWriteE,
  output logic        ALUSrcE,
  output logic        ALUSrcAE,
  output logic        MemWriteE,
  output logic [1:0]  ResultSrcE,
  output logic        JumpE,
  output logic [2:0]  BranchE,
  output logic        PCTargetSrcE,
  output logic [4:0]  ALUControlE,
  output logic        ValidE,
  output logic        IllegalE,
  output logic        MdBusy
);
  logic [6:0] w_op, w_f7;
  logic [2:0] w_f3, w_brc, w_br;
  logic [4:0] w_alu_b, w_alu_r, w_alu;
  logic [1:0] w_rs;
  logic w_rw, w_as, w_asa, w_mw, w_j, w_pts, w_ill, w_m, w_busy, w_unused;
  logic [15:0] w_ctl, r_ctl;
  logic [CNT_W-1:0] w_lat, r_cnt;
  logic r_valid, r_ill;
  assign w_op = InstrD[6:0];
  assign w_f3 = InstrD[14:12];
  assign w_f7 = InstrD[31:25];
  assign w_unused = ^{InstrD[24:15], InstrD[11:7]};
  assign w_alu_b = w_f3 == 3'd0 ? 5'd0 : w_f3 == 3'd1 ? 5'd5 : w_f3 == 3'd2 ? 5'd8 :
                   w_f3 == 3'd3 ? 5'd9 : w_f3 == 3'd4 ? 5'd2 :
                   w_f3 == 3'd5 ? (w_f7[5] ? 5'd7 : 5'd6) : w_f3 == 3'd6 ? 5'd3 : 5'd4;
  assign w_alu_r = w_f7 == 7'b0000001 ? {2'b10, w_f3} : (w_f3 == 3'd0 && w_f7[5]) ? 5'd1 : w_alu_b;
  // BEQ/BNE map to 1/2, BLT..BGEU to 3..6
  assign w_brc = w_f3[2] ? {1'b0, w_f3[1:0]} + 3'd3 : {2'b0, w_f3[0]} + 3'd1;
  always_comb begin
    ImmSrcD = 3'b000;
    w_rw = 1'b0; w_as = 1'b0; w_asa = 1'b0; w_mw = 1'b0; w_rs = 2'b00;
    w_j = 1'b0; w_br = 3'b000; w_pts = 1'b0; w_alu = 5'd0; w_ill = 1'b0; w_m = 1'b0;
    case (w_op)
      7'b0000011: begin w_rw = 1'b1; w_as = 1'b1; w_rs = 2'b01; end
      7'b0100011: begin ImmSrcD = 3'b001; w_mw = 1'b1; w_as = 1'b1; end
      7'b0110011: begin
        w_rw = 1'b1; w_alu = w_alu_r;
        w_m = M_EXT && w_f7 == 7'b0000001;
        w_ill = !(w_f7 == 7'b0000000 || w_f7 == 7'b0100000 || w_m);
      end
      7'b0010011: begin w_rw = 1'b1; w_as = 1'b1; w_alu = w_alu_b; end
      7'b1100011: begin ImmSrcD = 3'b010; w_alu = 5'd1; w_br = w_brc; w_ill = w_f3[2:1] == 2'b01; end
      7'b0110111: begin ImmSrcD = 3'b100; w_rw = 1'b1; w_as = 1'b1; w_alu = 5'd15; end
      7'b0010111: begin ImmSrcD = 3'b100; w_rw = 1'b1; w_as = 1'b1; w_asa = 1'b1; end
      7'b1101111: begin ImmSrcD = 3'b011; w_rw = 1'b1; w_j = 1'b1; w_rs = 2'b10; end
      7'b1100111: begin w_rw = 1'b1; w_as = 1'b1; w_j = 1'b1; w_rs = 2'b10; w_pts = 1'b1; end
      default: w_ill = 1'b1;
    endcase
  end
  assign w_ctl = w_ill ? '0 : {w_rw, w_as, w_asa, w_mw, w_rs, w_j, w_br, w_pts, w_alu};
  assign w_lat = w_f3[2] ? CNT_W'(DIV_LATENCY) : CNT_W'(MUL_LATENCY);
  assign w_busy = r_cnt != '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctl <= '0; r_valid <= 1'b0; r_ill <= 1'b0; r_cnt <= '0;
    end else if (w_busy) begin
      r_cnt <= r_cnt - 1'b1;
    end else if (FlushE || !ValidD) begin
      r_ctl <= '0; r_valid <= 1'b0; r_ill <= 1'b0;
    end else begin
      r_ctl <= w_ctl; r_valid <= 1'b1; r_ill <= w_ill;
      r_cnt <= w_m ? w_lat - 1'b1 : '0;
    end
  end
  assign {RegWriteE, ALUSrcE, ALUSrcAE, MemWriteE, ResultSrcE, JumpE, BranchE, PCTargetSrcE, ALUControlE} = r_ctl;
  assign ValidE = r_valid;
  assign IllegalE = r_ill;
  assign MdBusy = w_busy;
endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
- RV32I/M decode-and-control stage for the 5-stage pipeline core.
- Decodes the D-stage instruction word into main/branch/ALU control.
- Holds the decoded controls in a built-in ID/EX control register with flush (bubble) support.
- Sequences multi-cycle M-extension ops through a latency counter that holds the E stage and raises a stall request to the hazard unit.

Parameters:
- M_EXT, 1: 1 = decode MUL/DIV/REM (opcode 0110011, funct7 0000001); 0 = these encodings are illegal.
- MUL_LATENCY, 2: cycles a MUL/MULH/MULHSU/MULHU occupies E (>=1).
- DIV_LATENCY, 33: cycles a DIV/DIVU/REM/REMU occupies E (>=1).
- CNT_W, 6: width of the latency counter; must satisfy 2^CNT_W > max(MUL_LATENCY, DIV_LATENCY).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- InstrD  in  32  D-stage instruction word
- ValidD  in  1  InstrD is a real instruction (0 = bubble)
- FlushE  in  1  load bubble into E next edge (hazard unit)
- ImmSrcD  out  3  combinational: 000 I, 001 S, 010 B, 011 J, 100 U
- RegWriteE  out  1  registered
- ALUSrcE  out  1  registered; 1 = immediate operand
- ALUSrcAE  out  1  registered; 1 = PC operand (AUIPC)
- MemWriteE  out  1  registered
- ResultSrcE  out  2  registered; 00 ALU, 01 mem, 10 PC+4
- JumpE  out  1  registered
- BranchE  out  3  registered; 000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BLTU, 110 BGEU
- PCTargetSrcE  out  1  registered; 1 = ALU result is the jump target (JALR)
- ALUControlE  out  5  registered ALU / muldiv op
- ValidE  out  1  E holds a real instruction
- IllegalE  out  1  E instruction is an undecodable encoding
- MdBusy  out  1  E is occupied by an unfinished M op; hazard unit stalls F/D

Behaviour:
- Decode is combinational from InstrD[6:0], [14:12], [31:25]. Supported opcodes: LW, SW, R-type, I-ALU, branch, LUI, AUIPC, JAL, JALR; control values as listed in Ports.
- ALUControl codes:
  - ADD 00000, SUB 00001, XOR 00010, OR 00011, AND 00100
  - SLL 00101, SRL 00110, SRA 00111, SLT 01000, SLTU 01001, PASSB 01111
  - M ops: {2'b10, funct3}
- SUB only for R-type with funct7[5]=1. ADDI is always ADD. SRAI/SRA are selected by funct7[5] for both R-type and I-type. LW/SW/AUIPC/JALR use ADD; branches use SUB; LUI uses PASSB.
- Illegal encodings:
  - unknown opcode
  - branch funct3 010 or 011
  - M encoding with M_EXT=0
  - R-type funct7 not in {0000000, 0100000, 0000001}
- An illegal instruction with ValidD=1 loads IllegalE=1, ValidE=1, and all state-changing controls (RegWrite, MemWrite, Jump, Branch) = 0.
- E-register update priority each clk edge:
  1. rst: clears every registered output to 0 and the counter to 0.
  2. MdBusy=1: E holds all values; FlushE is ignored.
  3. FlushE=1: all registered outputs = 0 (bubble).
  4. Otherwise: load the decoded values. ValidD=0 loads a bubble.
- Latency counter (CNT_W bits):
  - When a valid M op loads into E and its latency L > 1, the counter is set to L-1.
  - MdBusy = (counter != 0), combinational from the counter.
  - While MdBusy=1, the counter decrements by 1 per cycle.
  - Result: an M op occupies E for exactly L cycles. With L=1 it never asserts MdBusy.
- Back-to-back M ops: the second loads on the cycle MdBusy is 0 and restarts the counter with no gap cycle.
- Reset mid-operation: MdBusy deasserts in the cycle after the rst edge; the op in E is discarded.
- ImmSrcD does not depend on ValidD or stall state.

Test Plan:
- Reset: rst=1 for 2 cycles with InstrD=0x00500093 -> all E outputs 0, MdBusy=0. After release, ADDI loads: RegWriteE=1, ALUSrcE=1, ALUControlE=00000, ValidE=1.
- Branch decode: InstrD=0x00B54463 (BLT) -> ImmSrcD=010, BranchE=011, ALUControlE=00001. InstrD=0x00B57463 (BGEU) -> BranchE=110.
- Shift and SUB: SRAI 0x4020D093 -> ALUControlE=00111. SUB 0x40B50533 -> 00001. ADDI with imm bit 10 set (0x40050513) -> 00000.
- Divide: DIV 0x02B54533 with DIV_LATENCY=33, FlushE pulsed mid-op -> MdBusy high for exactly 32 cycles, E stable throughout, ALUControlE=10100. A following MUL loads on the first MdBusy=0 edge, then MdBusy is high for 1 cycle.
- Illegal and flush: opcode 0x7F -> IllegalE=1, RegWriteE=0, MemWriteE=0. FlushE=1 with a valid SW in D -> E bubble (ValidE=0, MemWriteE=0).
- M_EXT=0 build: MUL 0x02B50533 -> IllegalE=1, MdBusy never asserts.
